// File: rtl/finger_counter.sv
// finger_counter
//   Counts fingers in a band of SCAN_ROWS rows just below a detected palm.
//   It follows the streamed 1-bit hand image with its own raster counters.
//   Within a column window around the palm it measures runs of hand pixels.
//   A run whose width lies in [MIN_FINGER_W, MAX_FINGER_W] counts as a finger.
//   The largest per-row count, clipped to 5, is reported once per palm.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   frame_start        strobe on pixel (0,0), qualified by pixel_valid
//   pixel_valid        object_image carries a pixel this cycle
//   object_image       1 = hand pixel
//   palm_valid         strobe: palm geometry inputs are final for this frame
//   start_of_palm_r    palm top row
//   start_of_palm_c    palm left column
//   end_of_palm_c      palm right column
//   palm_height        palm height in rows
//   finger_count       clipped finger count 0..5, held between strobes
//   count_valid        one-cycle strobe when finger_count is updated
//   busy               a palm has been accepted and its scan is pending
//   scan_err           with count_valid: the scan band was already passed
module finger_counter #(
  parameter int IMG_W        = 160,
  parameter int IMG_H        = 120,
  parameter int SCAN_ROWS    = 4,
  parameter int COL_MARGIN   = 8,
  parameter int MIN_FINGER_W = 2,
  parameter int MAX_FINGER_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic       object_image,
  input  logic       palm_valid,
  input  logic [7:0] start_of_palm_r,
  input  logic [7:0] start_of_palm_c,
  input  logic [7:0] end_of_palm_c,
  input  logic [7:0] palm_height,
  output logic [2:0] finger_count,
  output logic       count_valid,
  output logic       busy,
  output logic       scan_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ROW, S_SCAN, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [RW-1:0]  r_row;
  logic [CW-1:0]  r_col;
  logic [9:0]     r_scan_row, r_win_lo, r_win_hi;
  logic [7:0]     r_run_len;
  logic           r_in_run;
  logic [2:0]     r_row_fingers, r_best, r_finger_count;
  logic [7:0]     r_rows_done;
  logic           r_err;

  logic           w_fs;
  logic [RW-1:0]  w_cur_row;
  logic [CW-1:0]  w_cur_col;
  logic [9:0]     w_row10, w_col10;
  logic [7:0]     w_lo8, w_hi8;
  logic [9:0]     w_win_lo, w_win_hi, w_hi_m, w_srow_sum, w_scan_row;
  logic           w_enter, w_scan_px, w_in_win;
  logic [7:0]     w_len_nxt, w_close_len, w_rows_nxt;
  logic           w_inrun_nxt, w_close, w_row_end, w_scan_done;
  logic [2:0]     w_rf_nxt, w_best_nxt;
  logic           w_latch, w_to_done, w_err;

  // ---- raster tracking: position of the pixel presented this cycle ----
  assign w_fs      = pixel_valid & frame_start;
  assign w_cur_row = w_fs ? '0 : r_row;
  assign w_cur_col = w_fs ? '0 : r_col;
  assign w_row10   = 10'(r_row);
  assign w_col10   = 10'(r_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pixel_valid) begin
      if (10'(w_cur_col) == LAST_COL) begin
        r_col <= '0;
        r_row <= (10'(w_cur_row) == LAST_ROW) ? w_cur_row : w_cur_row + 1'b1;
      end else begin
        r_col <= w_cur_col + 1'b1;
        r_row <= w_cur_row;
      end
    end
  end

  // ---- geometry: order the palm columns, widen by the margin, clamp ----
  assign w_lo8      = (start_of_palm_c <= end_of_palm_c) ? start_of_palm_c : end_of_palm_c;
  assign w_hi8      = (start_of_palm_c <= end_of_palm_c) ? end_of_palm_c : start_of_palm_c;
  assign w_win_lo   = ({2'b00, w_lo8} < 10'(COL_MARGIN)) ? 10'd0
                                                         : {2'b00, w_lo8} - 10'(COL_MARGIN);
  assign w_hi_m     = {2'b00, w_hi8} + 10'(COL_MARGIN);
  assign w_win_hi   = (w_hi_m > LAST_COL) ? LAST_COL : w_hi_m;
  assign w_srow_sum = {2'b00, start_of_palm_r} + {2'b00, palm_height};
  assign w_scan_row = (w_srow_sum > LAST_ROW) ? LAST_ROW : w_srow_sum;

  // The first band pixel (scan_row, 0) is consumed in the same cycle that
  // WAIT_ROW hands over to SCAN, so it goes through the run logic too.
  assign w_enter   = pixel_valid && (w_row10 == r_scan_row) && (w_col10 == 10'd0);
  assign w_scan_px = pixel_valid && !w_fs &&
                     ((r_state == S_SCAN) || ((r_state == S_WAIT_ROW) && w_enter));
  assign w_in_win  = (w_col10 >= r_win_lo) && (w_col10 <= r_win_hi);

  // ---- run measurement and per-row finger accounting ----
  always_comb begin
    w_len_nxt   = r_run_len;
    w_inrun_nxt = r_in_run;
    w_rf_nxt    = r_row_fingers;
    w_close     = 1'b0;
    w_close_len = r_run_len;
    w_best_nxt  = r_best;
    w_rows_nxt  = r_rows_done;
    w_row_end   = 1'b0;
    if (w_scan_px) begin
      if (w_in_win) begin
        if (object_image) begin
          w_len_nxt   = (r_run_len == 8'hFF) ? r_run_len : r_run_len + 8'd1;
          w_inrun_nxt = 1'b1;
          // a run still open at the window edge ends there, edge pixel included
          if (w_col10 == r_win_hi) begin
            w_close     = 1'b1;
            w_close_len = w_len_nxt;
          end
        end else if (r_in_run) begin
          w_close     = 1'b1;
          w_close_len = r_run_len;
        end
      end
      if (w_close) begin
        if ((w_close_len >= 8'(MIN_FINGER_W)) && (w_close_len <= 8'(MAX_FINGER_W)))
          w_rf_nxt = (r_row_fingers == 3'd7) ? r_row_fingers : r_row_fingers + 3'd1;
        w_len_nxt   = 8'd0;
        w_inrun_nxt = 1'b0;
      end
      if (w_col10 == LAST_COL) begin
        w_row_end   = 1'b1;
        w_best_nxt  = (w_rf_nxt > r_best) ? w_rf_nxt : r_best;
        w_rf_nxt    = 3'd0;
        w_len_nxt   = 8'd0;
        w_inrun_nxt = 1'b0;
        w_rows_nxt  = r_rows_done + 8'd1;
      end
    end
  end

  assign w_scan_done = w_row_end &&
                       ((w_rows_nxt == 8'(SCAN_ROWS)) || (w_row10 == LAST_ROW));

  // ---- control FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_to_done   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a new frame in the same cycle wins over the palm strobe
        if (palm_valid && !w_fs) begin
          w_latch     = 1'b1;
          w_state_nxt = S_WAIT_ROW;
        end
      end
      S_WAIT_ROW: begin
        if (w_fs) begin
          w_state_nxt = S_IDLE;
        end else if ((w_row10 > r_scan_row) ||
                     ((w_row10 == r_scan_row) && (w_col10 != 10'd0))) begin
          w_state_nxt = S_DONE;
          w_to_done   = 1'b1;
          w_err       = 1'b1;
        end else if (w_enter) begin
          w_state_nxt = w_scan_done ? S_DONE : S_SCAN;
          w_to_done   = w_scan_done;
        end
      end
      S_SCAN: begin
        if (w_fs) begin
          w_state_nxt = S_IDLE;
        end else if (w_scan_done) begin
          w_state_nxt = S_DONE;
          w_to_done   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control FSM: state, geometry latch, scan accumulators, result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_scan_row     <= '0;
      r_win_lo       <= '0;
      r_win_hi       <= '0;
      r_run_len      <= '0;
      r_in_run       <= 1'b0;
      r_row_fingers  <= '0;
      r_best         <= '0;
      r_rows_done    <= '0;
      r_finger_count <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_scan_row    <= w_scan_row;
        r_win_lo      <= w_win_lo;
        r_win_hi      <= w_win_hi;
        r_run_len     <= '0;
        r_in_run      <= 1'b0;
        r_row_fingers <= '0;
        r_best        <= '0;
        r_rows_done   <= '0;
      end else if (w_scan_px) begin
        r_run_len     <= w_len_nxt;
        r_in_run      <= w_inrun_nxt;
        r_row_fingers <= w_rf_nxt;
        r_best        <= w_best_nxt;
        r_rows_done   <= w_rows_nxt;
      end
      if (w_to_done) begin
        r_err          <= w_err;
        r_finger_count <= w_err ? 3'd0 : ((w_best_nxt > 3'd5) ? 3'd5 : w_best_nxt);
      end
    end
  end

  assign finger_count = r_finger_count;
  assign count_valid  = (r_state == S_DONE);
  assign busy         = (r_state == S_WAIT_ROW) || (r_state == S_SCAN);
  assign scan_err     = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_finger_counter.sv
module tb_finger_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start, pixel_valid, object_image, palm_valid;
  logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_c, palm_height;
  logic [2:0] finger_count;
  logic       count_valid, busy, scan_err;

  finger_counter dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .pixel_valid    (pixel_valid),
    .object_image   (object_image),
    .palm_valid     (palm_valid),
    .start_of_palm_r(start_of_palm_r),
    .start_of_palm_c(start_of_palm_c),
    .end_of_palm_c  (end_of_palm_c),
    .palm_height    (palm_height),
    .finger_count   (finger_count),
    .count_valid    (count_valid),
    .busy           (busy),
    .scan_err       (scan_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] fc;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   img [120][160];

  // ---------------- stimulus helpers ----------------
  task automatic clear_img();
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++)
        img[r][c] = 1'b0;
  endtask

  task automatic paint(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        img[r][c] = 1'b1;
  endtask

  task automatic set_geom(input int r, input int h, input int c0, input int c1);
    start_of_palm_r = 8'(r);
    palm_height     = 8'(h);
    start_of_palm_c = 8'(c0);
    end_of_palm_c   = 8'(c1);
  endtask

  task automatic expect_result(input int fc, input bit err);
    exp_t e;
    e.fc  = 3'(fc);
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Streams n_pix raster pixels from (0,0); palm_valid rides on pixel palm_pix.
  task automatic run_frame(input int n_pix, input int palm_pix, input bit throttle,
                           input bit with_fs);
    for (int i = 0; i < n_pix; i++) begin
      @(negedge clk);
      pixel_valid  = 1'b1;
      frame_start  = with_fs && (i == 0);
      object_image = img[i / 160][i % 160];
      palm_valid   = (i == palm_pix);
      if (throttle) begin
        @(negedge clk);
        pixel_valid  = 1'b0;
        frame_start  = 1'b0;
        palm_valid   = 1'b0;
        object_image = 1'b1;
      end
    end
    @(negedge clk);
    pixel_valid  = 1'b0;
    frame_start  = 1'b0;
    palm_valid   = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && count_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_count_valid: got finger_count=%0d scan_err=%0d, wanted no strobe",
                 finger_count, scan_err);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (finger_count !== mon_e.fc)
          $display("FAIL finger_count: got %0d, wanted %0d", finger_count, mon_e.fc);
        else n_pass++;
        n_checks++;
        if (scan_err !== mon_e.err)
          $display("FAIL scan_err: got %0b, wanted %0b", scan_err, mon_e.err);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
          $display("FAIL busy_at_strobe: got %0b, wanted 0", busy);
        else n_pass++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (finger_count !== 3'd0) $display("FAIL reset_fc: got %0d, wanted 0", finger_count);
    else n_pass++;
    n_checks++;
    if (count_valid !== 1'b0) $display("FAIL reset_cv: got %0b, wanted 0", count_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, wanted 0", busy);
    else n_pass++;
    n_checks++;
    if (scan_err !== 1'b0) $display("FAIL reset_err: got %0b, wanted 0", scan_err);
    else n_pass++;
    // palm_valid together with frame_start in IDLE must not be accepted
    set_geom(0, 2, 60, 90);
    @(negedge clk);
    pixel_valid = 1'b1; frame_start = 1'b1; palm_valid = 1'b1; object_image = 1'b0;
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; palm_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL simultaneous_busy: got %0b, wanted 0", busy);
    else n_pass++;
  endtask

  task automatic test_three_fingers();
    clear_img();
    paint(70, 73, 62, 65);
    paint(70, 73, 72, 75);
    paint(70, 73, 84, 87);
    set_geom(40, 30, 60, 90);
    expect_result(3, 1'b0);
    run_frame(74 * 160, 5, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (count_valid !== 1'b1)
      $display("FAIL latency: count_valid=%0b one cycle after last band pixel, wanted 1", count_valid);
    else n_pass++;
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL three_fingers_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    clear_img();
    paint(2, 5, 60, 63);
    paint(2, 5, 70, 73);
    set_geom(0, 2, 60, 90);
    run_frame(4 * 160 + 20, 5, 1'b0, 1'b1);   // stops inside the third band row
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before: got %0b, wanted 1", busy);
    else n_pass++;
    @(negedge clk);
    pixel_valid = 1'b1; frame_start = 1'b1; object_image = 1'b0;
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy_after: got %0b, wanted 0", busy);
    else n_pass++;
    n_checks++;
    if (finger_count !== 3'd3) $display("FAIL abort_fc_held: got %0d, wanted 3", finger_count);
    else n_pass++;
    expect_result(2, 1'b0);
    run_frame(6 * 160, 5, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL abort_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic paint_width_img();
    clear_img();
    paint(2, 5, 55, 55);    // 1 pixel: too narrow
    paint(2, 5, 60, 72);    // 13 pixels: too wide
    paint(2, 5, 80, 84);    // 5 pixels: a finger
  endtask

  task automatic test_width_filter();
    paint_width_img();
    set_geom(0, 2, 60, 90);
    expect_result(1, 1'b0);
    run_frame(6 * 160, 5, 1'b0, 1'b1);
    clear_img();
    for (int k = 0; k < 6; k++) paint(2, 5, 54 + 6 * k, 56 + 6 * k);
    expect_result(5, 1'b0);
    run_frame(6 * 160, 5, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL width_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_clamp();
    clear_img();
    paint(2, 5, 0, 3);
    paint(2, 5, 150, 159);
    for (int sw = 0; sw < 2; sw++) begin
      if (sw == 0) set_geom(0, 2, 3, 155);
      else         set_geom(0, 2, 155, 3);
      expect_result(2, 1'b0);
      run_frame(6 * 160, 5, 1'b0, 1'b1);
    end
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL clamp_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_throttled();
    clear_img();
    paint(2, 2, 60, 62); paint(2, 2, 70, 72);
    paint(3, 3, 55, 57); paint(3, 3, 62, 64); paint(3, 3, 70, 72); paint(3, 3, 80, 82);
    paint(4, 5, 60, 62); paint(4, 5, 70, 72); paint(4, 5, 80, 82);
    set_geom(0, 2, 60, 90);
    for (int t = 0; t < 2; t++) begin
      expect_result(4, 1'b0);
      run_frame(6 * 160, 5, t[0], 1'b1);
    end
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL throttled_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    clear_img();
    set_geom(40, 30, 60, 90);
    run_frame(100, 5, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %0b, wanted 1", busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({finger_count, count_valid, busy, scan_err} !== 6'd0)
      $display("FAIL rstmid_outputs: got fc=%0d cv=%0b busy=%0b err=%0b, wanted all 0",
               finger_count, count_valid, busy, scan_err);
    else n_pass++;
    // raster restarts at (0,0) after reset even without a frame_start strobe
    paint_width_img();
    set_geom(0, 2, 60, 90);
    expect_result(1, 1'b0);
    run_frame(6 * 160, 5, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL rstmid_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_unreachable();
    clear_img();
    set_geom(100, 40, 60, 90);
    expect_result(0, 1'b1);
    run_frame(119 * 160 + 10, 119 * 160 + 5, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL unreachable_drain: %0d results outstanding, wanted 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; pixel_valid = 1'b0; object_image = 1'b0; palm_valid = 1'b0;
    set_geom(0, 0, 0, 0);
    test_reset();
    test_three_fingers();
    test_abort();
    test_width_filter();
    test_clamp();
    test_throttled();
    test_reset_mid_wait();
    test_unreachable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/finger_counter.md
Name: finger_counter

Overview:
- Downstream of palm identification.
- Consumes the latched palm geometry (palm start row/column, palm end column, palm height) and the same streamed 1-bit segmented hand image.
- Counts the fingers crossing a band of rows just beyond the palm, then reports a clipped count (0..5) once per frame to the gesture classifier.

Parameters:
- IMG_W, 160, image width in pixels; columns 0..IMG_W-1.
- IMG_H, 120, image height in rows; rows 0..IMG_H-1.
- SCAN_ROWS, 4, number of consecutive rows evaluated.
- COL_MARGIN, 8, columns added on each side of the palm span to form the scan window.
- MIN_FINGER_W, 2, minimum run length (pixels) accepted as a finger.
- MAX_FINGER_W, 12, maximum run length accepted as a finger.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle strobe coincident with pixel (0,0); only meaningful when pixel_valid=1
- pixel_valid  in  1  object_image is valid this cycle
- object_image  in  1  segmented hand pixel, 1 = hand
- palm_valid  in  1  one-cycle strobe: palm geometry inputs are stable and final for this frame
- start_of_palm_r  in  8  row where the palm was found
- start_of_palm_c  in  8  left palm column
- end_of_palm_c  in  8  right palm column
- palm_height  in  8  palm height in rows
- finger_count  out  3  result, 0..5
- count_valid  out  1  one-cycle strobe when finger_count is updated
- busy  out  1  high from palm_valid acceptance until DONE or abort
- scan_err  out  1  high with count_valid when the scan band was unreachable

Behaviour:
- Reset: finger_count=0, count_valid=0, busy=0, scan_err=0, state IDLE, raster counters 0.
- Raster tracking:
  - row/col counters advance only on pixel_valid.
  - A frame_start pixel is (0,0).
  - col wraps at IMG_W-1 and row increments on wrap.
  - row saturates at IMG_H-1.
- Geometry latch (palm_valid in IDLE):
  - scan_row = start_of_palm_r + palm_height, computed 9-bit, saturated to IMG_H-1.
  - win_lo = start_of_palm_c - COL_MARGIN, floored at 0.
  - win_hi = end_of_palm_c + COL_MARGIN, capped at IMG_W-1.
  - If end_of_palm_c < start_of_palm_c, swap the two columns before applying margins.
  - palm_valid outside IDLE is ignored.
- States:
  - IDLE: wait for palm_valid. On palm_valid, latch geometry, busy=1, go to WAIT_ROW.
  - WAIT_ROW: go to SCAN on the first valid pixel with row==scan_row and col==0.
    - If, at acceptance or later, the current row > scan_row, or the current row == scan_row with col > 0, go to DONE with scan_err=1 and result 0.
  - SCAN: per valid pixel inside [win_lo, win_hi]:
    - Hand pixel: run_len++ (saturating at 255), in_run=1.
    - Non-hand pixel while in_run: close the run.
    - The run also closes at col==win_hi, inclusive of that pixel.
    - A closed run with MIN_FINGER_W <= run_len <= MAX_FINGER_W increments row_fingers (saturating at 7).
    - At col==IMG_W-1: best = max(best, row_fingers), clear row_fingers and run state, rows_done++.
    - After SCAN_ROWS rows, or on reaching row IMG_H-1 end, go to DONE.
  - DONE (one cycle):
    - finger_count = min(best, 5); count_valid=1; busy=0; scan_err per the above.
    - Next state IDLE.
    - best and rows_done clear on entry to WAIT_ROW.
- Abort: frame_start while busy returns the block to IDLE with no count_valid, and finger_count is held.
- Simultaneous events: palm_valid and frame_start in the same cycle in IDLE gives frame_start priority; the geometry is not latched.
- Latency: count_valid is asserted the cycle after the last pixel of the final scan row is consumed.
- Reset mid-scan: immediate return to reset values.
- finger_count holds between strobes.

Test Plan:
- Three fingers:
  - Stimulus: palm_r=40, height=30, cols 60..90; rows 70..73 contain runs at cols 62-65, 72-75, 84-87.
  - Required: count_valid with finger_count=3, scan_err=0, busy deasserted the same cycle.
- Width filtering:
  - Stimulus: runs of 1, 13 and 5 pixels in the band.
  - Required: finger_count=1.
  - Stimulus: a 6-finger-like pattern (6 valid runs).
  - Required: finger_count=5 (clip).
- Window clamping:
  - Stimulus: start_c=3, end_c=155.
  - Required: window 0..159; a run touching col 159 closes at row end and is counted.
- Unreachable band:
  - Stimulus: start_r=100, height=40 gives scan_row=119; palm_valid issued while row=119, col=5.
  - Required: count_valid, finger_count=0, scan_err=1.
- Abort:
  - Stimulus: frame_start during SCAN row 2.
  - Required: no count_valid, busy=0 next cycle, previous finger_count retained; a new palm_valid then scans normally.
- Throttled input and reset:
  - Stimulus: pixel_valid toggling 50%.
  - Required: identical result to the continuous-stream case.
  - Stimulus: rst mid-WAIT_ROW.
  - Required: all outputs 0, IDLE.
